// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared types for the victim cache controller
package lc3b_types;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WB_SETUP    = 3'd1,
      WB          = 3'd2,
      FETCH_SETUP = 3'd3,
      FETCH       = 3'd4
   } vc_ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, holds at all-ones
module sat_counter #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [width-1:0] count
);

   logic [width-1:0] count_q;
   logic [width-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {width{1'b1}})) begin
         count_d = count_q + {{(width-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/victimcache_control.sv
// rtl/victimcache_control.sv - victim cache fill/writeback sequencer with event counters
module victimcache_control
   import lc3b_types::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 mem_wdirty,
   input  logic                 hit,
   input  logic                 evict,
   input  logic                 pmem_resp,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic                 r_mux_sel,
   output logic                 w_mux_sel,
   output logic                 control_resp,
   output logic                 dirty,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
);

   vc_ctrl_state_t state_q;
   vc_ctrl_state_t state_d;
   logic           hit_inc;
   logic           miss_inc;
   logic           wb_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      r_mux_sel    = 1'b0;
      w_mux_sel    = 1'b0;
      control_resp = 1'b0;
      dirty        = mem_wdirty;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      wb_inc       = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A write-in masks any concurrent read; the read is retried by L2.
            if (mem_write) begin
               if (evict) begin
                  state_d = WB_SETUP;
                  wb_inc  = 1'b1;
               end else if (hit) begin
                  hit_inc = 1'b1;
               end
            end else if (mem_read) begin
               if (!hit) begin
                  state_d  = FETCH_SETUP;
                  miss_inc = 1'b1;
               end else if (!evict) begin
                  hit_inc = 1'b1;
               end
            end
         end
         WB_SETUP: begin
            w_mux_sel = 1'b1;
            state_d   = WB;
         end
         WB: begin
            w_mux_sel  = 1'b1;
            pmem_write = 1'b1;
            if (pmem_resp) begin
               state_d = IDLE;
            end
         end
         FETCH_SETUP: begin
            state_d = FETCH;
         end
         FETCH: begin
            pmem_read    = 1'b1;
            r_mux_sel    = 1'b1;
            control_resp = pmem_resp;
            if (pmem_resp) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   sat_counter #(.width(CNT_WIDTH)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (hit_count)
   );

   sat_counter #(.width(CNT_WIDTH)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_inc),
      .count (miss_count)
   );

   sat_counter #(.width(CNT_WIDTH)) u_wb_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wb_inc),
      .count (wb_count)
   );

endmodule

// File: tb/tb_victimcache_control.sv
// tb/tb_victimcache_control.sv - directed self-checking bench for victimcache_control
module tb_victimcache_control;
   import lc3b_types::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   logic mem_read = 1'b0, mem_write = 1'b0, mem_wdirty = 1'b0;
   logic hit = 1'b0, evict = 1'b0, pmem_resp = 1'b0;

   logic pmem_read, pmem_write, r_mux_sel, w_mux_sel, control_resp, dirty;
   logic [15:0] hit_count, miss_count, wb_count;

   logic pmem_read2, pmem_write2, r_mux_sel2, w_mux_sel2, control_resp2, dirty2;
   logic [1:0] hit_count2, miss_count2, wb_count2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   victimcache_control #(.CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdirty(mem_wdirty), .hit(hit), .evict(evict), .pmem_resp(pmem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .r_mux_sel(r_mux_sel),
      .w_mux_sel(w_mux_sel), .control_resp(control_resp), .dirty(dirty),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );

   victimcache_control #(.CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst2), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdirty(mem_wdirty), .hit(hit), .evict(evict), .pmem_resp(pmem_resp),
      .pmem_read(pmem_read2), .pmem_write(pmem_write2), .r_mux_sel(r_mux_sel2),
      .w_mux_sel(w_mux_sel2), .control_resp(control_resp2), .dirty(dirty2),
      .hit_count(hit_count2), .miss_count(miss_count2), .wb_count(wb_count2)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] st();
      return 32'(dut.state_q);
   endfunction

   initial begin
      tick();
      tick();
      check("rst_state", st(), 32'(IDLE));
      check("rst_strobes", {pmem_read, pmem_write, r_mux_sel, w_mux_sel, control_resp}, 0);
      check("rst_counts", {hit_count, miss_count}, 0);
      check("rst_wb", wb_count, 0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) tick();
      check("idle_state", st(), 32'(IDLE));
      check("idle_counts", {hit_count, miss_count, wb_count}, 0);

      // read hit
      mem_read = 1'b1; hit = 1'b1;
      #1;
      check("hit_no_pread", pmem_read, 0);
      tick();
      check("hit_state", st(), 32'(IDLE));
      check("hit_count1", hit_count, 1);
      mem_read = 1'b0; hit = 1'b0;

      // read miss with pmem_resp on the 5th fetch cycle
      mem_read = 1'b1;
      #1;
      check("miss_idle_pread", pmem_read, 0);
      tick();
      check("miss_setup_state", st(), 32'(FETCH_SETUP));
      check("miss_setup_strobes", {pmem_read, pmem_write, r_mux_sel, w_mux_sel, control_resp}, 0);
      check("miss_count1", miss_count, 1);
      tick();
      for (int i = 1; i <= 5; i++) begin
         if (i == 5) pmem_resp = 1'b1;
         #1;
         check("fetch_pread", pmem_read, 1);
         check("fetch_rmux", r_mux_sel, 1);
         check("fetch_cresp", control_resp, (i == 5) ? 1 : 0);
         check("fetch_excl", pmem_write, 0);
         if (i < 5) tick();
      end
      tick();
      pmem_resp = 1'b0; mem_read = 1'b0;
      #1;
      check("miss_done_state", st(), 32'(IDLE));
      check("miss_done_pread", pmem_read, 0);
      check("miss_count_hold", miss_count, 1);

      // dirty eviction, pmem_resp on the 4th writeback cycle
      mem_write = 1'b1; evict = 1'b1; mem_wdirty = 1'b1;
      #1;
      check("wb_idle_dirty", dirty, 1);
      check("wb_idle_wmux", w_mux_sel, 0);
      tick();
      check("wbs_state", st(), 32'(WB_SETUP));
      check("wbs_wmux", w_mux_sel, 1);
      check("wbs_pwrite", pmem_write, 0);
      check("wbs_dirty", dirty, 1);
      check("wb_count1", wb_count, 1);
      tick();
      for (int i = 1; i <= 4; i++) begin
         if (i == 4) pmem_resp = 1'b1;
         #1;
         check("wb_pwrite", pmem_write, 1);
         check("wb_wmux", w_mux_sel, 1);
         check("wb_excl", pmem_read, 0);
         check("wb_dirty", dirty, 1);
         if (i < 4) tick();
      end
      tick();
      pmem_resp = 1'b0; evict = 1'b0;
      #1;
      check("wb_done_state", st(), 32'(IDLE));
      check("wb_done_strobes", {pmem_write, w_mux_sel}, 0);
      tick();
      mem_write = 1'b0; mem_wdirty = 1'b0;
      check("wb_fill_state", st(), 32'(IDLE));
      check("wb_fill_hits", hit_count, 1);
      check("wb_count_hold", wb_count, 1);

      // reset on the 3rd fetch cycle
      mem_read = 1'b1;
      tick();
      check("rmid_miss2", miss_count, 2);
      tick();
      tick();
      tick();
      check("rmid_fetch", st(), 32'(FETCH));
      rst = 1'b1;
      tick();
      check("rmid_state", st(), 32'(IDLE));
      check("rmid_strobes", {pmem_read, r_mux_sel}, 0);
      check("rmid_counts", {hit_count, miss_count, wb_count}, 0);
      rst = 1'b0; mem_read = 1'b0;

      // saturation on the 2-bit instance
      rst2 = 1'b0;
      mem_read = 1'b1; hit = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("sat_hits", hit_count2, (k < 3) ? k : 3);
      end
      check("nosat_hits", hit_count, 5);
      mem_read = 1'b0; hit = 1'b0;

      // simultaneous read/write: write wins
      mem_read = 1'b1; mem_write = 1'b1; evict = 1'b1;
      tick();
      check("rw_state", st(), 32'(WB_SETUP));
      check("rw_miss", miss_count, 0);
      check("rw_wb", wb_count, 1);
      mem_read = 1'b0; mem_write = 1'b0; evict = 1'b0;
      tick();
      pmem_resp = 1'b1;
      #1;
      check("rw_pwrite", pmem_write, 1);
      tick();
      check("rw_done", st(), 32'(IDLE));

      // pmem_resp in IDLE is ignored
      tick();
      check("spur_state", st(), 32'(IDLE));
      check("spur_strobes", {pmem_read, pmem_write, control_resp}, 0);
      pmem_resp = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/victimcache_control.md
Name: victimcache_control

Overview:
- Sequencing FSM for the 8-way fully-associative victim cache datapath, between the L2 (request side) and physical memory.
- Hits and clean write-ins are completed by the datapath alone in one cycle.
- This block sequences read-miss fills from pmem and dirty-victim writebacks, and drives the datapath's r_mux_sel, w_mux_sel, control_resp and dirty controls.
- It also keeps saturating hit/miss/writeback event counters for performance tests.

Parameters:
CNT_WIDTH, 16, width of each saturating event counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
mem_read  input  1  upstream read request, held until mem_resp
mem_write  input  1  upstream write-in (victim line from L2), held until mem_resp
mem_wdirty  input  1  dirty status of the line being written in
hit  input  1  datapath tag hit
evict  input  1  datapath: write miss whose LRU way is valid and dirty
pmem_resp  input  1  physical memory completion strobe
pmem_read  output  1  physical memory read strobe
pmem_write  output  1  physical memory write strobe
r_mux_sel  output  1  datapath: route pmem_rdata to mem_rdata
w_mux_sel  output  1  datapath: select LRU victim address/data, clear dirty bits, block mem_resp
control_resp  output  1  datapath: miss-fill completion, forms mem_resp
dirty  output  1  datapath: dirty bit to load with write-in data
hit_count  output  CNT_WIDTH  requests completed by datapath without pmem
miss_count  output  CNT_WIDTH  read misses sent to pmem
wb_count  output  CNT_WIDTH  dirty victims written back

Behaviour:
- States: IDLE, WB_SETUP, WB, FETCH_SETUP, FETCH. Reset state is IDLE.
- Reset clears all counters. All outputs are 0 in IDLE except dirty.
- dirty = mem_wdirty in every state (combinational pass-through).
- IDLE:
  - mem_write & evict -> WB_SETUP; wb_count++.
  - mem_read & ~mem_write & ~hit -> FETCH_SETUP; miss_count++.
  - (mem_read|mem_write) & hit & ~evict -> stay in IDLE; hit_count++. The datapath responds this cycle.
  - mem_write & ~hit & ~evict -> stay in IDLE. The datapath writes into the LRU way; no count.
  - Simultaneous mem_read & mem_write: mem_write takes priority; the read is not evaluated.
- WB_SETUP:
  - w_mux_sel=1 for exactly one cycle, so the datapath's registered pmem_address/pmem_wdata capture the LRU victim.
  - -> WB unconditionally.
- WB:
  - w_mux_sel=1, pmem_write=1, held until pmem_resp.
  - On pmem_resp -> IDLE.
  - The victim's dirty bit is now clear, so evict falls and the pending write completes in IDLE on the next cycle.
- FETCH_SETUP:
  - All strobes 0 for one cycle, so pmem_address captures mem_address.
  - -> FETCH.
- FETCH:
  - pmem_read=1, r_mux_sel=1.
  - control_resp = pmem_resp, combinational in the same cycle, so mem_rdata takes pmem_rdata while it is valid.
  - On pmem_resp -> IDLE.
  - The fill is not installed in the victim cache: read-through only, and the LRU is not updated on control_resp.
- Latency:
  - Read miss: 2 cycles plus pmem latency.
  - Dirty write-in: 2 cycles plus pmem latency, then 1 IDLE cycle for the write.
  - Hit: 0 controller cycles.
- pmem_read and pmem_write are never asserted together. Each remains high continuously until pmem_resp.
- Upstream request dropped mid-transaction: the started pmem transaction still completes and returns to IDLE. control_resp may pulse and must be harmless.
- Counters saturate at all-ones and never wrap. Each counter increments only on the IDLE transition/decision cycle.
- rst asserted in any state, including mid-WB or mid-FETCH: next cycle is IDLE, strobes drop, counters are 0. The outstanding pmem transaction is abandoned.
- pmem_resp while in IDLE or a SETUP state is ignored.

Decomposition:
- Add the state enum vc_ctrl_state_t (IDLE, WB_SETUP, WB, FETCH_SETUP, FETCH) to lc3b_types so benches can probe state by name.
- Counter logic goes in one sub-module, sat_counter #(width): inputs clk, rst, inc; output count. It is instantiated three times.
- FSM next-state and outputs use the same two-process style as the existing cache controllers.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all strobes 0, counters 0, state IDLE. Drive mem_read=0, mem_write=0 for 10 cycles -> no change.
- Read hit: mem_read=1, hit=1, evict=0 -> stays IDLE; hit_count 0->1; pmem_read never asserted.
- Read miss: mem_read=1, hit=0, pmem_resp after 5 cycles of pmem_read ->
  - Cycle 1: FETCH_SETUP, no strobes.
  - pmem_read=1 and r_mux_sel=1 from cycle 2.
  - control_resp=1 only on the pmem_resp cycle, then IDLE.
  - miss_count=1.
- Dirty eviction: mem_write=1, evict=1, mem_wdirty=1 ->
  - w_mux_sel=1 with pmem_write=0 for one cycle, then pmem_write=w_mux_sel=1 until pmem_resp (4 cycles).
  - Then IDLE; dirty=1 throughout; wb_count=1.
- Reset mid-fetch: assert rst on the 3rd cycle of FETCH -> next cycle pmem_read=0, r_mux_sel=0, IDLE, miss_count=0.
- Saturation: CNT_WIDTH=2, issue 5 read hits -> hit_count reads 1,2,3,3,3. Simultaneous mem_read=mem_write=1, hit=0, evict=1 -> WB_SETUP taken, miss_count unchanged.
